// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage definitions: opcodes, funct codes, ALU ops, FSM states.
package rv32_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 codes
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_MUL     = 3'b000;

    // funct7 codes
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Multiplier iteration counter: 6 bits, counts 0..31
    localparam int unsigned MulCntW  = 6;
    localparam logic [5:0]  MUL_LAST = 6'd31;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd
    } alu_op_e;

    typedef enum logic {
        StRun,
        StMul
    } exec_state_e;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ins);
        return {ins[31:12], 12'h000};
    endfunction

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit RV32I integer ALU; shifts use the low 5 bits of i_b.
module alu32
    import rv32_pkg::*;
(
    input  alu_op_e     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);

    // Operation select
    always_comb begin
        o_result = '0;
        case (i_op)
            AluAdd:  o_result = i_a + i_b;
            AluSub:  o_result = i_a - i_b;
            AluSll:  o_result = i_a << i_b[4:0];
            AluSlt:  o_result = {31'b0, $signed(i_a) < $signed(i_b)};
            AluSltu: o_result = {31'b0, i_a < i_b};
            AluXor:  o_result = i_a ^ i_b;
            AluSrl:  o_result = i_a >> i_b[4:0];
            AluSra:  o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
            AluOr:   o_result = i_a | i_b;
            AluAnd:  o_result = i_a & i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// RV32I execute stage: alignment register, operand forwarding, decode, ALU and
// registered write-back. Optional shift-add multiplier enabled by RV32_MUL_EN.
module exec_stage
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] ins,
    input  logic [31:0] pc,
    input  logic [31:0] rso1,
    input  logic [31:0] rso2,
    output logic [4:0]  wb_reg,
    output logic        wb_en,
    output logic [31:0] wb_val,
    output logic        stall,
    output logic        illegal
);

    logic        r_ex_valid;
    logic [31:0] r_ex_ins;
    logic [31:0] r_ex_pc;

    logic        r_wb_en;
    logic        r_illegal;
    logic [4:0]  r_wb_reg;
    logic [31:0] r_wb_val;

    logic [6:0]  w_opc;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_op1;
    logic [31:0] w_op2;

    alu_op_e     w_alu_op;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_res;
    logic        w_legal;
    logic        w_is_mul;
    logic        w_stall;
    logic        w_adv;
    logic        w_in_run;

    assign w_opc = r_ex_ins[6:0];
    assign w_rd  = r_ex_ins[11:7];
    assign w_f3  = r_ex_ins[14:12];
    assign w_rs1 = r_ex_ins[19:15];
    assign w_rs2 = r_ex_ins[24:20];
    assign w_f7  = r_ex_ins[31:25];

    // Forward the instruction retiring this cycle over the stale register-file read
    assign w_op1 = (r_wb_en && (r_wb_reg != 5'd0) && (r_wb_reg == w_rs1)) ? r_wb_val : rso1;
    assign w_op2 = (r_wb_en && (r_wb_reg != 5'd0) && (r_wb_reg == w_rs2)) ? r_wb_val : rso2;

`ifdef RV32_MUL_EN
    exec_state_e r_state;
    exec_state_e w_state_nxt;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [MulCntW-1:0] r_cnt;
    logic        w_mul_start;
    logic        w_mul_done;
    logic [31:0] w_acc_nxt;

    assign w_in_run    = (r_state == StRun);
    assign w_mul_start = w_in_run && r_ex_valid && w_is_mul;
    assign w_mul_done  = (r_state == StMul) && (r_cnt == MUL_LAST);
    assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
    assign w_stall     = (r_state == StMul) || w_mul_start;
    // Upstream has been holding the next instruction, so take it on the finishing
    // edge; otherwise the held MUL would be re-decoded and restarted.
    assign w_adv       = !w_stall || w_mul_done;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StRun:   if (w_mul_start) w_state_nxt = StMul;
            StMul:   if (w_mul_done) w_state_nxt = StRun;
            default: w_state_nxt = StRun;
        endcase
    end

    // Shift-add multiplier: consume one multiplier bit per cycle, LSB first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_mul_start) begin
            r_mcand  <= w_op1;
            r_mplier <= w_op2;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == StMul) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= w_mul_done ? '0 : r_cnt + 6'd1;
        end
    end
`else
    assign w_in_run = 1'b1;
    assign w_stall  = 1'b0;
    assign w_adv    = 1'b1;
`endif

    // Decode the aligned instruction into ALU controls and legality
    always_comb begin
        w_alu_op = AluAdd;
        w_alu_a  = w_op1;
        w_alu_b  = w_op2;
        w_legal  = 1'b0;
        w_is_mul = 1'b0;
        case (w_opc)
            OPC_OP: begin
                if (w_f7 == F7_BASE) begin
                    w_legal = 1'b1;
                    unique case (w_f3)
                        F3_ADD_SUB: w_alu_op = AluAdd;
                        F3_SLL:     w_alu_op = AluSll;
                        F3_SLT:     w_alu_op = AluSlt;
                        F3_SLTU:    w_alu_op = AluSltu;
                        F3_XOR:     w_alu_op = AluXor;
                        F3_SRL_SRA: w_alu_op = AluSrl;
                        F3_OR:      w_alu_op = AluOr;
                        F3_AND:     w_alu_op = AluAnd;
                    endcase
                end else if (w_f7 == F7_ALT) begin
                    if (w_f3 == F3_ADD_SUB) begin
                        w_alu_op = AluSub;
                        w_legal  = 1'b1;
                    end else if (w_f3 == F3_SRL_SRA) begin
                        w_alu_op = AluSra;
                        w_legal  = 1'b1;
                    end
`ifdef RV32_MUL_EN
                end else if ((w_f7 == F7_MULDIV) && (w_f3 == F3_MUL)) begin
                    w_is_mul = 1'b1;
`endif
                end
            end
            OPC_OP_IMM: begin
                w_alu_b = imm_i(r_ex_ins);
                unique case (w_f3)
                    F3_ADD_SUB: begin w_alu_op = AluAdd;  w_legal = 1'b1; end
                    F3_SLT:     begin w_alu_op = AluSlt;  w_legal = 1'b1; end
                    F3_SLTU:    begin w_alu_op = AluSltu; w_legal = 1'b1; end
                    F3_XOR:     begin w_alu_op = AluXor;  w_legal = 1'b1; end
                    F3_OR:      begin w_alu_op = AluOr;   w_legal = 1'b1; end
                    F3_AND:     begin w_alu_op = AluAnd;  w_legal = 1'b1; end
                    F3_SLL: begin
                        w_alu_op = AluSll;
                        w_legal  = (w_f7 == F7_BASE);
                    end
                    F3_SRL_SRA: begin
                        w_alu_op = (w_f7 == F7_ALT) ? AluSra : AluSrl;
                        w_legal  = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                    end
                endcase
            end
            OPC_LUI: begin
                w_alu_a = 32'd0;
                w_alu_b = imm_u(r_ex_ins);
                w_legal = 1'b1;
            end
            OPC_AUIPC: begin
                w_alu_a = r_ex_pc;
                w_alu_b = imm_u(r_ex_ins);
                w_legal = 1'b1;
            end
            default: ;
        endcase
    end

    alu32 u_alu (
        .i_op     (w_alu_op),
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .o_result (w_alu_res)
    );

    // Alignment register: pairs ins/pc with the register-file data arriving a cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_ins   <= '0;
            r_ex_pc    <= '0;
        end else if (w_adv) begin
            r_ex_valid <= in_valid;
            r_ex_ins   <= ins;
            r_ex_pc    <= pc;
        end
    end

    // Write-back and illegal registers; illegal ops leave wb_reg/wb_val untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_reg  <= '0;
            r_wb_val  <= '0;
            r_wb_en   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_wb_en   <= 1'b0;
            r_illegal <= 1'b0;
`ifdef RV32_MUL_EN
            if (w_mul_done) begin
                r_wb_reg <= w_rd;
                r_wb_val <= w_acc_nxt;
                r_wb_en  <= (w_rd != 5'd0);
            end else
`endif
            if (r_ex_valid && w_in_run && !w_is_mul) begin
                if (w_legal) begin
                    r_wb_reg <= w_rd;
                    r_wb_val <= w_alu_res;
                    r_wb_en  <= (w_rd != 5'd0);
                end else begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    assign wb_reg  = r_wb_reg;
    assign wb_en   = r_wb_en;
    assign wb_val  = r_wb_val;
    assign stall   = w_stall;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_exec_stage.sv
// Directed self-checking bench for exec_stage; the multiply section follows RV32_MUL_EN.
module tb_exec_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] rso1;
    logic [31:0] rso2;
    logic [4:0]  wb_reg;
    logic        wb_en;
    logic [31:0] wb_val;
    logic        stall;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rf [32];

    exec_stage dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .ins      (ins),
        .pc       (pc),
        .rso1     (rso1),
        .rso2     (rso2),
        .wb_reg   (wb_reg),
        .wb_en    (wb_en),
        .wb_val   (wb_val),
        .stall    (stall),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first register file: read data for ins appears one cycle later
    always @(posedge clk) begin
        if (wb_en && (wb_reg != 5'd0)) rf[wb_reg] <= wb_val;
        if (ins[19:15] == 5'd0)                        rso1 <= 32'd0;
        else if (wb_en && (wb_reg == ins[19:15]))      rso1 <= wb_val;
        else                                           rso1 <= rf[ins[19:15]];
        if (ins[24:20] == 5'd0)                        rso2 <= 32'd0;
        else if (wb_en && (wb_reg == ins[24:20]))      rso2 <= wb_val;
        else                                           rso2 <= rf[ins[24:20]];
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one instruction for one clock edge
    task automatic send(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        ins      = i;
        pc       = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        ins      = 32'd0;
        pc       = 32'd0;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t_ins [9];
    logic [4:0]  t_rd  [9];
    logic [31:0] t_val [9];

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; ins = 32'd0; pc = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_wb_en",   {31'b0, wb_en},   32'd0);
        check_eq("rst_wb_reg",  {27'b0, wb_reg},  32'd0);
        check_eq("rst_wb_val",  wb_val,           32'd0);
        check_eq("rst_illegal", {31'b0, illegal}, 32'd0);
        check_eq("rst_stall",   {31'b0, stall},   32'd0);

        // x1=5, x2=7, then ADD x3,x1,x2
        send(enc_i(12'd5, 5'd0, 3'b000, 5'd1), 32'h0);
        send(enc_i(12'd7, 5'd0, 3'b000, 5'd2), 32'h4);
        check_eq("addi_x1", wb_val, 32'd5);
        send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h8);
        check_eq("addi_x2", wb_val, 32'd7);
        idle();
        check_eq("add_wb_en",  {31'b0, wb_en},  32'd1);
        check_eq("add_wb_reg", {27'b0, wb_reg}, 32'd3);
        check_eq("add_wb_val", wb_val,          32'd12);
        idle();
        check_eq("add_wb_en_one_cycle", {31'b0, wb_en}, 32'd0);

        // ADDI x4,x0,-1 then dependent SRLI x5,x4,28 with no bubble
        send(enc_i(12'hFFF, 5'd0, 3'b000, 5'd4), 32'h10);
        send(enc_i(12'd28, 5'd4, 3'b101, 5'd5), 32'h14);
        check_eq("addi_m1_reg", {27'b0, wb_reg}, 32'd4);
        check_eq("addi_m1_val", wb_val,          32'hFFFFFFFF);
        idle();
        check_eq("srli_reg", {27'b0, wb_reg}, 32'd5);
        check_eq("srli_val", wb_val,          32'h0000000F);

        // ALU table: x1=5 x2=7 x4=-1 x5=0xF
        t_ins[0] = enc_r(7'h20, 5'd2,  5'd1,  3'b000, 5'd12); t_rd[0] = 12; t_val[0] = 32'hFFFFFFFE;
        t_ins[1] = enc_r(7'h00, 5'd1,  5'd4,  3'b010, 5'd9);  t_rd[1] = 9;  t_val[1] = 32'd1;
        t_ins[2] = enc_r(7'h00, 5'd1,  5'd4,  3'b011, 5'd10); t_rd[2] = 10; t_val[2] = 32'd0;
        t_ins[3] = enc_r(7'h20, 5'd1,  5'd4,  3'b101, 5'd11); t_rd[3] = 11; t_val[3] = 32'hFFFFFFFF;
        t_ins[4] = enc_r(7'h00, 5'd1,  5'd5,  3'b001, 5'd15); t_rd[4] = 15; t_val[4] = 32'h000001E0;
        t_ins[5] = enc_r(7'h00, 5'd15, 5'd5,  3'b110, 5'd19); t_rd[5] = 19; t_val[5] = 32'h000001EF;
        t_ins[6] = enc_i(12'h7F0, 5'd5,  3'b100, 5'd16);      t_rd[6] = 16; t_val[6] = 32'h000007FF;
        t_ins[7] = enc_i(12'hFF0, 5'd4,  3'b111, 5'd17);      t_rd[7] = 17; t_val[7] = 32'hFFFFFFF0;
        t_ins[8] = enc_i(12'h401, 5'd12, 3'b101, 5'd18);      t_rd[8] = 18; t_val[8] = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) begin
            send(t_ins[i], 32'h20 + 32'(4 * i));
            if (i > 0) begin
                check_eq($sformatf("alu%0d_reg", i - 1), {27'b0, wb_reg}, {27'b0, t_rd[i - 1]});
                check_eq($sformatf("alu%0d_val", i - 1), wb_val, t_val[i - 1]);
            end
        end
        idle();
        check_eq("alu8_reg", {27'b0, wb_reg}, {27'b0, t_rd[8]});
        check_eq("alu8_val", wb_val, t_val[8]);

        // ADD x0 retires without a write strobe
        send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 32'h60);
        idle();
        check_eq("add_x0_wb_en",   {31'b0, wb_en},   32'd0);
        check_eq("add_x0_illegal", {31'b0, illegal}, 32'd0);

        // Unsupported opcode 0x7F
        send(32'h0000007F, 32'h64);
        idle();
        check_eq("ill_pulse",  {31'b0, illegal}, 32'd1);
        check_eq("ill_wb_en",  {31'b0, wb_en},   32'd0);
        check_eq("ill_wb_val", wb_val,           32'd12);
        idle();
        check_eq("ill_one_cycle", {31'b0, illegal}, 32'd0);

        // LUI / AUIPC
        send(enc_u(20'h12345, 5'd7, 7'b0110111), 32'h100);
        send(enc_u(20'h00001, 5'd8, 7'b0010111), 32'h104);
        check_eq("lui_val", wb_val, 32'h12345000);
        idle();
        check_eq("auipc_reg", {27'b0, wb_reg}, 32'd8);
        check_eq("auipc_val", wb_val,          32'h00001104);

        // Multiply: x1=-1, x2=3, MUL x6,x1,x2
        send(enc_i(12'hFFF, 5'd0, 3'b000, 5'd1), 32'h200);
        send(enc_i(12'd3, 5'd0, 3'b000, 5'd2), 32'h204);
        send(enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd6), 32'h208);
`ifdef RV32_MUL_EN
        // Dependent ADD x13,x6,x6 held upstream during the stall
        in_valid = 1'b1;
        ins      = enc_r(7'h00, 5'd6, 5'd6, 3'b000, 5'd13);
        pc       = 32'h20C;
        n = 0;
        while ((stall === 1'b1) && (n < 60)) begin
            n++;
            @(posedge clk);
            #1;
        end
        check_eq("mul_stall_cycles", 32'(n), 32'd33);
        check_eq("mul_wb_en",  {31'b0, wb_en},  32'd1);
        check_eq("mul_wb_reg", {27'b0, wb_reg}, 32'd6);
        check_eq("mul_wb_val", wb_val,          32'hFFFFFFFD);
        idle();
        check_eq("mul_dep_reg", {27'b0, wb_reg}, 32'd13);
        check_eq("mul_dep_val", wb_val,          32'hFFFFFFFA);

        // Reset at iteration 10 aborts the multiply
        send(enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd6), 32'h300);
        in_valid = 1'b0;
        ins      = 32'd0;
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        check_eq("mul_mid_stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("mul_abort_wb_en", {31'b0, wb_en}, 32'd0);
        check_eq("mul_abort_stall", {31'b0, stall}, 32'd0);
        send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd14), 32'h400);
        idle();
        check_eq("post_rst_add_en",  {31'b0, wb_en},  32'd1);
        check_eq("post_rst_add_reg", {27'b0, wb_reg}, 32'd14);
        check_eq("post_rst_add_val", wb_val,          32'd2);
`else
        n = 0;
        check_eq("nomul_stall", {31'b0, stall}, 32'd0);
        idle();
        check_eq("nomul_illegal", {31'b0, illegal}, 32'd1);
        check_eq("nomul_wb_en",   {31'b0, wb_en},   32'd0);
        check_eq("nomul_stall2",  {31'b0, stall},   32'd0);
        idle();
        check_eq("nomul_ill_one_cycle", {31'b0, illegal}, 32'(n));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
